icache_controller: RTL and testbench

- Direct-mapped instruction cache sitting between the fetch stage and main_memory.
- Serves 32-bit instruction fetches from 64-bit (8-byte) lines.
- On a miss, raises mem_miss and waits for main_memory's one-cycle mem_write strobe carrying the line in mem_block.
- Fills the line, then returns the requested word; fetch is stalled for the duration.

---
 rtl/icache_controller.sv | 134 +++++++++++++
 tb/tb_icache_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache: 8-byte lines, 32-bit fetch, blocking fill from main_memory.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_controller #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              mem_miss,
  output logic [ADDR_W-1:0] mem_addr,
`ifdef ICACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  input  logic [63:0]       mem_block,
  input  logic              mem_write
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - 3 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, FILL} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:2]     addr_q;
  logic [63:0]           data_mem [LINES];
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [LINES-1:0]      valid_q;
  logic [63:0]           line_q;
  logic                  stall_q;
  logic                  flush_pend;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;

  logic accept, clr_valid, lookup_hit, lookup_miss, fill_we, fill_done;

  wire unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  assign idx   = addr_q[3+INDEX_BITS-1:3];
  assign tag   = addr_q[ADDR_W-1:3+INDEX_BITS];
  assign hit   = valid_q[idx] && (tag_mem[idx] == tag);
  assign stall = stall_q | flush_pend;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req && !flush) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? IDLE : MISS;
      MISS:    if (mem_write) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pending flush is applied on the IDLE edge, so a request accepted on
  // that same edge looks up against the already-cleared valid bits.
  always_comb begin
    accept      = (state_q == IDLE) && cpu_req && !flush;
    clr_valid   = (state_q == IDLE) && (flush || flush_pend);
    lookup_hit  = (state_q == LOOKUP) && hit;
    lookup_miss = (state_q == LOOKUP) && !hit;
    fill_we     = (state_q == MISS) && mem_write;
    fill_done   = (state_q == FILL);
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[idx] <= mem_block;
      tag_mem[idx]  <= tag;
      line_q        <= mem_block;
    end
    if (accept) addr_q <= cpu_addr[ADDR_W-1:2];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= '0;
      flush_pend  <= 1'b0;
      stall_q     <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      mem_miss    <= 1'b0;
      mem_addr    <= '0;
    end else begin
      if (clr_valid) valid_q <= '0;
      // A flush seen during the miss leaves the freshly filled line invalid.
      else if (fill_we && !flush && !flush_pend) valid_q[idx] <= 1'b1;

      if (state_q == IDLE) flush_pend <= 1'b0;
      else if (flush)      flush_pend <= 1'b1;

      if (accept)                        stall_q <= 1'b1;
      else if (lookup_hit || fill_done)  stall_q <= 1'b0;

      if (lookup_hit)     instr <= addr_q[2] ? data_mem[idx][63:32] : data_mem[idx][31:0];
      else if (fill_done) instr <= addr_q[2] ? line_q[63:32] : line_q[31:0];
      instr_valid <= lookup_hit || fill_done;

      if (lookup_miss) begin
        mem_miss <= 1'b1;
        mem_addr <= {addr_q[ADDR_W-1:3], 3'b000};
      end else if (fill_we) begin
        mem_miss <= 1'b0;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit && hit_count != 32'hFFFF_FFFF)   hit_count  <= hit_count + 32'd1;
      if (lookup_miss && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Directed table-driven bench for icache_controller plus multi-cycle corner sequences.
module tb_icache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_miss;
  logic [31:0] mem_addr;
  logic [63:0] mem_block;
  logic        mem_write;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  icache_controller #(.INDEX_BITS(4), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .mem_miss    (mem_miss),
    .mem_addr    (mem_addr),
`ifdef ICACHE_STATS_EN
    .hit_count   (hit_count),
    .miss_count  (miss_count),
`endif
    .mem_block   (mem_block),
    .mem_write   (mem_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          flush_before;
    bit          exp_hit;
    logic [31:0] exp_instr;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Memory image: byte at address a is a[7:0] ^ {a[11:8],4'h0}.
  function automatic logic [63:0] line_of(input logic [31:0] a);
    logic [63:0] l;
    logic [31:0] ba;
    for (int k = 0; k < 8; k++) begin
      ba = {a[31:3], 3'b000} + 32'(k);
      l[8*k +: 8] = ba[7:0] ^ {ba[11:8], 4'h0};
    end
    return l;
  endfunction

  task automatic fetch(input logic [31:0] a, input bit exp_hit, input logic [31:0] exp_i);
    cpu_addr = a;
    cpu_req  = 1'b1;
    step();
    cpu_req = 1'b0;
    chk($sformatf("stall@lookup a=%h", a), stall, 1);
    step();
    if (exp_hit) begin
      chk($sformatf("hit_valid a=%h", a), instr_valid, 1);
      chk($sformatf("hit_instr a=%h", a), instr, exp_i);
      chk($sformatf("hit_no_miss a=%h", a), mem_miss, 0);
      chk($sformatf("hit_stall_low a=%h", a), stall, 0);
    end else begin
      chk($sformatf("miss_valid_low a=%h", a), instr_valid, 0);
      chk($sformatf("mem_miss a=%h", a), mem_miss, 1);
      chk($sformatf("mem_addr a=%h", a), mem_addr, {a[31:3], 3'b000});
      repeat (3) step();
      chk($sformatf("mem_miss_held a=%h", a), mem_miss, 1);
      mem_block = line_of(a);
      mem_write = 1'b1;
      step();
      mem_write = 1'b0;
      chk($sformatf("mem_miss_drop a=%h", a), mem_miss, 0);
      chk($sformatf("fill_valid_low a=%h", a), instr_valid, 0);
      step();
      chk($sformatf("fill_valid a=%h", a), instr_valid, 1);
      chk($sformatf("fill_instr a=%h", a), instr, exp_i);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h0000_0004, 1'b0, 1'b0, 32'h0706_0504};
    vecs[1]  = '{32'h0000_0000, 1'b0, 1'b1, 32'h0302_0100};
    vecs[2]  = '{32'h0000_0080, 1'b0, 1'b0, 32'h8382_8180};
    vecs[3]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0302_0100};
    vecs[4]  = '{32'h0000_0084, 1'b0, 1'b0, 32'h8786_8584};
    vecs[5]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0302_0100};
    vecs[6]  = '{32'h0000_003C, 1'b0, 1'b0, 32'h3F3E_3D3C};
    vecs[7]  = '{32'h0000_0038, 1'b0, 1'b1, 32'h3B3A_3938};
    vecs[8]  = '{32'h0000_0000, 1'b0, 1'b1, 32'h0302_0100};
    vecs[9]  = '{32'h0000_0000, 1'b1, 1'b0, 32'h0302_0100};
    vecs[10] = '{32'h0000_0104, 1'b0, 1'b0, 32'h1716_1514};
    vecs[11] = '{32'h0000_0100, 1'b0, 1'b1, 32'h1312_1110};

    cpu_req   = 1'b0;
    cpu_addr  = '0;
    flush     = 1'b0;
    mem_block = '0;
    mem_write = 1'b0;
    do_reset();

    chk("reset_instr", instr, 0);
    chk("reset_valid", instr_valid, 0);
    chk("reset_stall", stall, 0);
    chk("reset_mem_miss", mem_miss, 0);
    chk("reset_mem_addr", mem_addr, 0);

    foreach (vecs[i]) begin
      if (vecs[i].flush_before) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      fetch(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_instr);
    end

    // Flush arriving while the miss is outstanding.
    cpu_addr = 32'h0000_0008;
    cpu_req  = 1'b1;
    step();
    cpu_req = 1'b0;
    step();
    chk("fm_mem_miss", mem_miss, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fm_stall_pending", stall, 1);
    step();
    mem_block = line_of(32'h0000_0008);
    mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    step();
    chk("fm_valid", instr_valid, 1);
    chk("fm_instr", instr, 32'h0B0A_0908);
    chk("fm_stall_flush_cycle", stall, 1);
    step();
    chk("fm_stall_released", stall, 0);
    fetch(32'h0000_0008, 1'b0, 32'h0B0A_0908);
    fetch(32'h0000_0000, 1'b0, 32'h0302_0100);

    // Reset dropped three cycles into a miss.
    cpu_addr = 32'h0000_0010;
    cpu_req  = 1'b1;
    step();
    cpu_req = 1'b0;
    step();
    chk("rm_mem_miss", mem_miss, 1);
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rm_mem_miss_low", mem_miss, 0);
    chk("rm_stall_low", stall, 0);
    chk("rm_valid_low", instr_valid, 0);
    mem_block = line_of(32'h0000_0010);
    mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    chk("rm_late_write_miss", mem_miss, 0);
    step();
    chk("rm_late_write_valid", instr_valid, 0);
    chk("rm_late_write_stall", stall, 0);
    fetch(32'h0000_0010, 1'b0, 32'h1312_1110);

    // Back-to-back hits with cpu_req held through the instr_valid cycle.
    cpu_addr = 32'h0000_0010;
    cpu_req  = 1'b1;
    step();
    step();
    chk("b2b_first_valid", instr_valid, 1);
    chk("b2b_first_instr", instr, 32'h1312_1110);
    cpu_addr = 32'h0000_0014;
    step();
    cpu_req = 1'b0;
    chk("b2b_second_stall", stall, 1);
    chk("b2b_second_gap", instr_valid, 0);
    step();
    chk("b2b_second_valid", instr_valid, 1);
    chk("b2b_second_instr", instr, 32'h1716_1514);

`ifdef ICACHE_STATS_EN
    do_reset();
    chk("stats_reset_hits", hit_count, 0);
    chk("stats_reset_misses", miss_count, 0);
    fetch(32'h0000_0000, 1'b0, 32'h0302_0100);
    fetch(32'h0000_0004, 1'b1, 32'h0706_0504);
    fetch(32'h0000_0000, 1'b1, 32'h0302_0100);
    fetch(32'h0000_0080, 1'b0, 32'h8382_8180);
    chk("stats_hits", hit_count, 2);
    chk("stats_misses", miss_count, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stats_flush_keeps_hits", hit_count, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
